noc_mem_responder: RTL



---
 rtl/noc_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/noc_mem_responder.sv
`default_nettype none
// noc_mem_responder: memory-side NoC endpoint; buffers request flits, performs them on a local
// word memory and returns one response flit per request addressed back to the requester.  Rev 1.0
module noc_mem_responder #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 128,
   parameter int ROUTE_BITS = 2,
   parameter int REQ_DEPTH  = 2,
   parameter int MEM_DEPTH  = 16,
   parameter int MEM_ID     = 0
) (
   input  logic                             clk,
   input  logic                             rst_l,
   input  logic                             req_enq,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] req_in,
   output logic                             req_full,
   output logic                             resp_enq,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] resp_out,
   input  logic                             resp_full_downstream,
   output logic                             busy
);
   localparam int FW  = ADDR_WIDTH + DATA_WIDTH;
   localparam int MIW = $clog2(MEM_DEPTH);
   localparam int PW  = $clog2(REQ_DEPTH);
   localparam int OPB = ADDR_WIDTH - 2*ROUTE_BITS - 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] SEND = 2'd2;

   logic [FW-1:0]         req_buf [REQ_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW:0]           count;
   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [ADDR_WIDTH-1:0] resp_addr;
   logic [DATA_WIDTH-1:0] resp_data;

   logic                  push;
   logic                  pop;
   logic [FW-1:0]         head;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_wr;
   logic [MIW-1:0]        head_idx;
   logic [ADDR_WIDTH-1:0] hdr_resp;
   logic                  unused_hdr;

   assign req_full  = (count == (PW+1)'(REQ_DEPTH));
   assign push      = req_enq && !req_full;
   assign pop       = (state == IDLE) && (count != '0);
   assign head      = req_buf[rd_ptr];
   assign head_addr = head[FW-1 -: ADDR_WIDTH];
   assign head_data = head[DATA_WIDTH-1:0];
   assign head_wr   = head_addr[OPB];
   assign head_idx  = head_addr[MIW-1:0];
   // destination and padding bits of the request header carry no meaning here
   assign unused_hdr = ^head_addr;

   always_comb begin
      hdr_resp                                   = '0;
      hdr_resp[ADDR_WIDTH-1 -: ROUTE_BITS]       = head_addr[ADDR_WIDTH-ROUTE_BITS-1 -: ROUTE_BITS];
      hdr_resp[ADDR_WIDTH-ROUTE_BITS-1 -: ROUTE_BITS] = ROUTE_BITS'(MEM_ID);
      hdr_resp[OPB]                              = head_wr;
      hdr_resp[MIW-1:0]                          = head_idx;
   end

   always_ff @(posedge clk) begin
      if (push)
         req_buf[wr_ptr] <= req_in;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // single-port word memory: write or registered read, issued at pop time
   always_ff @(posedge clk) begin
      if (pop && head_wr)
         mem[head_idx] <= head_data;
      if (pop && !head_wr)
         mem_rdata <= mem[head_idx];
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state     <= IDLE;
         resp_addr <= '0;
         resp_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  resp_addr <= hdr_resp;
                  if (head_wr) begin
                     resp_data <= head_data;
                     state     <= SEND;
                  end else begin
                     state     <= READ;
                  end
               end
            end
            READ: begin
               resp_data <= mem_rdata;
               state     <= SEND;
            end
            SEND: begin
               if (!resp_full_downstream)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign resp_enq = (state == SEND) && !resp_full_downstream;
   assign resp_out = {resp_addr, resp_data};
   assign busy     = (state != IDLE) || (count != '0);

endmodule
`default_nettype wire
